// File: rtl/bus8085_pkg.sv
// Shared types for the 8085-style bus master: cycle types, T-states and the
// per-cycle status encoding driven on iomn/s1/s0.
package bus8085_pkg;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        MEMRD = 3'd1,
        MEMWR = 3'd2,
        IORD  = 3'd3,
        IOWR  = 3'd4
    } cyc_t;

    typedef enum logic [2:0] {
        IDLE,
        T1,
        T2,
        TW,
        T3,
        T4
    } tstate_t;

    typedef struct packed {
        logic iomn;
        logic s1;
        logic s0;
    } status_t;

    function automatic logic cyc_valid(input logic [2:0] t);
        return (t <= 3'd4);
    endfunction

    function automatic logic cyc_is_write(input logic [2:0] t);
        return (t == MEMWR) || (t == IOWR);
    endfunction

    // Idle status (IO, 0/0) doubles as the value for undefined cycle types.
    function automatic status_t cyc_status(input logic [2:0] t);
        status_t s;
        case (t)
            FETCH:   s = '{iomn: 1'b0, s1: 1'b1, s0: 1'b1};
            MEMRD:   s = '{iomn: 1'b0, s1: 1'b1, s0: 1'b0};
            MEMWR:   s = '{iomn: 1'b0, s1: 1'b0, s0: 1'b1};
            IORD:    s = '{iomn: 1'b1, s1: 1'b1, s0: 1'b0};
            IOWR:    s = '{iomn: 1'b1, s1: 1'b0, s0: 1'b1};
            default: s = '{iomn: 1'b1, s1: 1'b0, s0: 1'b0};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Counts consecutive TW cycles of one machine cycle; expired flags the last
// tolerated wait state so the master can abort at the end of it.
module bus_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int CW = ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Saturating at LAST keeps a ready-released cycle from wrapping the count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/bus_cycle_ctrl.sv
// 8085-style multiplexed-bus master: one core request becomes one T1/T2/TW/T3[/T4]
// machine cycle. Define BUS_TIMEOUT_EN to abort cycles stuck in TW for MAX_WAIT states.
module bus_cycle_ctrl
    import bus8085_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter bit FETCH_T4 = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_type,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        ale,
    inout  wire  [7:0]  ad,
    output logic [7:0]  a_hi,
    output logic        iomn,
    output logic        rdn,
    output logic        wrn,
    output logic        s1,
    output logic        s0,
    input  logic        ready,
    output tstate_t     dbg_state
);

    tstate_t     state_q, state_d;
    logic [2:0]  typ_q, typ_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        ale_q, ale_d;
    logic        rdn_q, rdn_d;
    logic        wrn_q, wrn_d;
    logic        iomn_q, iomn_d;
    logic        s1_q, s1_d;
    logic        s0_q, s0_d;
    logic [7:0]  a_hi_q, a_hi_d;
    logic [7:0]  ad_out_q, ad_out_d;
    logic        ad_oe_q, ad_oe_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        err_pend_q, err_pend_d;
    logic        last_state;
    logic        accept;
    logic        timeout_abort;
    status_t     st;

    // Handshake: req_* transfers on a posedge with req_valid && req_ready; req_ready
    // depends on state only. An invalid type accepted while a cycle completes gets its
    // error response one cycle later (err_pend_q), so responses never collide.
    assign last_state = ((state_q == T3) && !(FETCH_T4 && (typ_q == FETCH))) || (state_q == T4);
    assign req_ready  = ((state_q == IDLE) && !err_pend_q) || last_state;
    assign accept     = req_valid && req_ready;

`ifdef BUS_TIMEOUT_EN
    logic wait_expired;

    bus_wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == T1),
        .count   (state_q == TW),
        .expired (wait_expired)
    );

    assign timeout_abort = (state_q == TW) && !ready && wait_expired;
`else
    // TW is unbounded here; MAX_WAIT only matters when the timer is built.
    assign timeout_abort = (MAX_WAIT < 0);
`endif

    always_comb begin
        state_d     = state_q;
        typ_d       = typ_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        err_pend_d  = 1'b0;

        case (state_q)
            IDLE: state_d = IDLE;
            T1:   state_d = T2;
            T2:   state_d = ready ? T3 : TW;
            TW: begin
                if (ready) begin
                    state_d = T3;
                end else if (timeout_abort) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            T3: begin
                if (!cyc_is_write(typ_q)) begin
                    rsp_rdata_d = ad;
                end
                if (FETCH_T4 && (typ_q == FETCH)) begin
                    state_d = T4;
                end else begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                end
            end
            T4: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (err_pend_q) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
        end

        if (accept) begin
            typ_d   = req_type;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            if (cyc_valid(req_type)) begin
                state_d = T1;
            end else begin
                state_d = IDLE;
                if (rsp_valid_d) begin
                    err_pend_d = 1'b1;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
        end

        // Bus pins are decoded from the state being entered so they are registered.
        st       = cyc_status(typ_d);
        ale_d    = 1'b0;
        rdn_d    = 1'b1;
        wrn_d    = 1'b1;
        ad_oe_d  = 1'b0;
        ad_out_d = ad_out_q;
        a_hi_d   = a_hi_q;
        iomn_d   = iomn_q;
        s1_d     = s1_q;
        s0_d     = s0_q;
        case (state_d)
            IDLE: begin
                iomn_d = 1'b1;
                s1_d   = 1'b0;
                s0_d   = 1'b0;
            end
            T1: begin
                ale_d    = 1'b1;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d[7:0];
                a_hi_d   = addr_d[15:8];
                iomn_d   = st.iomn;
                s1_d     = st.s1;
                s0_d     = st.s0;
            end
            T2, TW, T3: begin
                if (cyc_is_write(typ_d)) begin
                    wrn_d    = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = wdata_d;
                end else begin
                    rdn_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            typ_q       <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ale_q       <= 1'b0;
            rdn_q       <= 1'b1;
            wrn_q       <= 1'b1;
            iomn_q      <= 1'b1;
            s1_q        <= 1'b0;
            s0_q        <= 1'b0;
            a_hi_q      <= '0;
            ad_out_q    <= '0;
            ad_oe_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            err_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            typ_q       <= typ_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ale_q       <= ale_d;
            rdn_q       <= rdn_d;
            wrn_q       <= wrn_d;
            iomn_q      <= iomn_d;
            s1_q        <= s1_d;
            s0_q        <= s0_d;
            a_hi_q      <= a_hi_d;
            ad_out_q    <= ad_out_d;
            ad_oe_q     <= ad_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_pend_q  <= err_pend_d;
        end
    end

    assign ad        = ad_oe_q ? ad_out_q : 8'bz;
    assign ale       = ale_q;
    assign rdn       = rdn_q;
    assign wrn       = wrn_q;
    assign iomn      = iomn_q;
    assign s1        = s1_q;
    assign s0        = s0_q;
    assign a_hi      = a_hi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign dbg_state = state_q;

endmodule
